// File: rtl/elliptic_curve_structs.sv
// Shared elliptic-curve types for the MSM datapath.
package elliptic_curve_structs;

  localparam int unsigned MSM_SCALAR_W = 256;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } curve_point_t;

endpackage

// File: rtl/msm_input_loader_pkg.sv
// Helpers shared by the MSM input loader and its bank sub-module.
package msm_input_loader_pkg;

  // Index width that stays legal for a single-entry batch.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msm_input_loader_if.sv
// Valid/ready stream carrying (point, scalar) pairs into the loader.
interface msm_input_loader_if;
  import elliptic_curve_structs::*;

  logic                    s_valid;
  logic                    s_ready;
  curve_point_t            s_point;
  logic [MSM_SCALAR_W-1:0] s_scalar;
  logic                    s_last;

  modport master (output s_valid, output s_point, output s_scalar, output s_last,
                  input s_ready);
  modport slave  (input s_valid, input s_point, input s_scalar, input s_last,
                  output s_ready);
endinterface

// File: rtl/msm_batch_bank.sv
// One batch bank: LENGTH point/scalar registers, single write port, full-array read.
module msm_batch_bank
  import elliptic_curve_structs::*;
  import msm_input_loader_pkg::*;
#(
  parameter  int unsigned LENGTH = 2,
  localparam int unsigned IDX_W  = idx_w(LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 Reset_n,
  input  logic                                 i_we,
  input  logic [IDX_W-1:0]                     i_idx,
  input  curve_point_t                         i_point,
  input  logic [MSM_SCALAR_W-1:0]              i_scalar,
  output curve_point_t [LENGTH-1:0]            o_points,
  output logic [LENGTH-1:0][MSM_SCALAR_W-1:0]  o_scalars
);

  curve_point_t [LENGTH-1:0]           r_points;
  logic [LENGTH-1:0][MSM_SCALAR_W-1:0] r_scalars;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_points  <= '0;
      r_scalars <= '0;
    end else if (i_we) begin
      r_points[i_idx]  <= i_point;
      r_scalars[i_idx] <= i_scalar;
    end
  end

  assign o_points  = r_points;
  assign o_scalars = r_scalars;

endmodule

// File: rtl/msm_input_loader.sv
// Ping-pong batch collector that feeds msm_naive and sequences its Reset/Done.
module msm_input_loader
  import elliptic_curve_structs::*;
  import msm_input_loader_pkg::*;
#(
  parameter int unsigned LENGTH = 2
) (
  input  logic                                 clk,
  input  logic                                 Reset_n,
  msm_input_loader_if.slave                    s,
  output curve_point_t [LENGTH-1:0]            G_out,
  output logic [LENGTH-1:0][MSM_SCALAR_W-1:0]  x_out,
  output logic                                 msm_start,
  input  logic                                 msm_done,
  output logic                                 busy,
  output logic                                 err,
  output logic [15:0]                          batches_issued
);

  localparam int unsigned IDX_W = idx_w(LENGTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_GUARD, ST_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_wr_sel, r_rd_sel;
  logic [IDX_W-1:0]   r_wr_idx;
  logic [1:0]         r_bank_full;
  logic               r_err;
  logic [15:0]        r_batches;

  logic               w_xfer, w_idx_last, w_commit, w_frame_err, w_done_acc;
  logic [1:0]         w_bank_we;
  curve_point_t [LENGTH-1:0]           w_points0, w_points1;
  logic [LENGTH-1:0][MSM_SCALAR_W-1:0] w_scalars0, w_scalars1;

  assign s.s_ready   = !r_bank_full[r_wr_sel];
  assign w_xfer      = s.s_valid && s.s_ready;
  assign w_idx_last  = (r_wr_idx == IDX_W'(LENGTH - 1));
  assign w_commit    = w_xfer && s.s_last && w_idx_last;
  assign w_frame_err = w_xfer && (s.s_last != w_idx_last);
  assign w_done_acc  = (r_state == ST_WAIT) && msm_done;
  assign w_bank_we   = {w_xfer && r_wr_sel, w_xfer && !r_wr_sel};

  msm_batch_bank #(.LENGTH(LENGTH)) u_bank0 (
    .clk(clk), .Reset_n(Reset_n), .i_we(w_bank_we[0]), .i_idx(r_wr_idx),
    .i_point(s.s_point), .i_scalar(s.s_scalar),
    .o_points(w_points0), .o_scalars(w_scalars0)
  );

  msm_batch_bank #(.LENGTH(LENGTH)) u_bank1 (
    .clk(clk), .Reset_n(Reset_n), .i_we(w_bank_we[1]), .i_idx(r_wr_idx),
    .i_point(s.s_point), .i_scalar(s.s_scalar),
    .o_points(w_points1), .o_scalars(w_scalars1)
  );

  // Commit and Done never touch the same bank: a full read bank blocks s_ready
  // whenever wr_sel points at it, so both updates may land in one cycle.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_wr_idx    <= '0;
      r_bank_full <= '0;
      r_err       <= 1'b0;
      r_batches   <= '0;
    end else begin
      if (w_xfer) begin
        if (w_commit) begin
          r_bank_full[r_wr_sel] <= 1'b1;
          r_wr_sel              <= ~r_wr_sel;
          r_wr_idx              <= '0;
        end else if (w_frame_err) begin
          r_err    <= 1'b1;
          r_wr_idx <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_done_acc) begin
        r_bank_full[r_rd_sel] <= 1'b0;
        r_rd_sel              <= ~r_rd_sel;
        r_batches             <= r_batches + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_bank_full[r_rd_sel]) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_GUARD;
      ST_GUARD: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (msm_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Gated so a reset landing on the START cycle never reaches the msm.
  assign msm_start      = (r_state == ST_START) && Reset_n;
  assign busy           = (r_state != ST_IDLE);
  assign err            = r_err;
  assign batches_issued = r_batches;
  assign G_out          = r_rd_sel ? w_points1  : w_points0;
  assign x_out          = r_rd_sel ? w_scalars1 : w_scalars0;

endmodule

// File: tb/tb_msm_input_loader.sv
// Directed bench for msm_input_loader with a hand-driven msm Done.
module tb_msm_input_loader;
  import elliptic_curve_structs::*;

  logic clk = 1'b0;
  logic Reset_n;
  logic msm_done;
  logic msm_start, busy, err;
  logic [15:0] batches_issued;
  curve_point_t [1:0]           G_out;
  logic [1:0][MSM_SCALAR_W-1:0] x_out;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;

  msm_input_loader_if sif();

  msm_input_loader #(.LENGTH(2)) dut (
    .clk(clk), .Reset_n(Reset_n), .s(sif.slave),
    .G_out(G_out), .x_out(x_out), .msm_start(msm_start), .msm_done(msm_done),
    .busy(busy), .err(err), .batches_issued(batches_issued)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         v, l;
    logic [255:0] px, py, sc;
    logic         d;
    logic         rdy, st, bsy, er;
    logic [15:0]  cnt;
    logic [255:0] g0x, x1;
  } vec_t;

  function automatic vec_t mk(input logic v, l, input int px, py, sc, input logic d,
                              input logic rdy, st, bsy, er, input int cnt, g0x, x1);
    vec_t t;
    t.v = v; t.l = l; t.px = 256'(px); t.py = 256'(py); t.sc = 256'(sc); t.d = d;
    t.rdy = rdy; t.st = st; t.bsy = bsy; t.er = er;
    t.cnt = 16'(cnt); t.g0x = 256'(g0x); t.x1 = 256'(x1);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (msm_start) n_start++;
  endtask

  task automatic send(input int px, py, sc, input logic l);
    sif.s_valid  = 1'b1;
    sif.s_point  = {256'(px), 256'(py)};
    sif.s_scalar = 256'(sc);
    sif.s_last   = l;
    step();
    sif.s_valid  = 1'b0;
    sif.s_last   = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (msm_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 256'(seen), 256'(1));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_ready"}, 256'(sif.s_ready), 256'(1));
    chk({nm, "_start"}, 256'(msm_start), 256'(0));
    chk({nm, "_busy"},  256'(busy), 256'(0));
    chk({nm, "_err"},   256'(err), 256'(0));
    chk({nm, "_cnt"},   256'(batches_issued), 256'(0));
    chk({nm, "_G"},     256'(G_out != '0), 256'(0));
    chk({nm, "_x"},     256'(x_out != '0), 256'(0));
  endtask

  vec_t vt[12];

  initial begin
    // columns: v l px py sc done | ready start busy err count G_out[0].x x_out[1]
    vt[0]  = mk(1, 0,  6,  1, 18, 0,  1, 0, 0, 0, 0,  6,  0);
    vt[1]  = mk(1, 1, 17,  6, 80, 0,  1, 0, 0, 0, 0,  6, 80);
    vt[2]  = mk(0, 0,  0,  0,  0, 0,  1, 1, 1, 0, 0,  6, 80);
    vt[3]  = mk(1, 0, 17,  6, 80, 0,  1, 0, 1, 0, 0,  6, 80);
    vt[4]  = mk(1, 1,  6,  1, 18, 0,  0, 0, 1, 0, 0,  6, 80);
    vt[5]  = mk(1, 0, 99, 99,  7, 0,  0, 0, 1, 0, 0,  6, 80);
    vt[6]  = mk(1, 1, 99, 99,  7, 1,  1, 0, 0, 0, 1, 17, 18);
    vt[7]  = mk(0, 0,  0,  0,  0, 0,  1, 1, 1, 0, 1, 17, 18);
    vt[8]  = mk(0, 0,  0,  0,  0, 0,  1, 0, 1, 0, 1, 17, 18);
    vt[9]  = mk(0, 0,  0,  0,  0, 0,  1, 0, 1, 0, 1, 17, 18);
    vt[10] = mk(0, 0,  0,  0,  0, 1,  1, 0, 0, 0, 2,  6, 80);
    vt[11] = mk(0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 2,  6, 80);

    Reset_n = 1'b0; msm_done = 1'b0;
    sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_point = '0; sif.s_scalar = '0;
    step(); step();
    Reset_n = 1'b1;
    chk_reset_state("reset");
    n_start = 0;

    // Single batch, ping-pong and back-pressure
    for (int i = 0; i < 12; i++) begin
      sif.s_valid  = vt[i].v;
      sif.s_last   = vt[i].l;
      sif.s_point  = {vt[i].px, vt[i].py};
      sif.s_scalar = vt[i].sc;
      msm_done     = vt[i].d;
      step();
      chk($sformatf("vec%0d_ready", i), 256'(sif.s_ready), 256'(vt[i].rdy));
      chk($sformatf("vec%0d_start", i), 256'(msm_start), 256'(vt[i].st));
      chk($sformatf("vec%0d_busy", i),  256'(busy), 256'(vt[i].bsy));
      chk($sformatf("vec%0d_err", i),   256'(err), 256'(vt[i].er));
      chk($sformatf("vec%0d_cnt", i),   256'(batches_issued), 256'(vt[i].cnt));
      chk($sformatf("vec%0d_g0x", i),   G_out[0].x, vt[i].g0x);
      chk($sformatf("vec%0d_x1", i),    x_out[1], vt[i].x1);
    end
    sif.s_valid = 1'b0; msm_done = 1'b0;
    chk("table_start_pulses", 256'(n_start), 256'(2));

    // Framing errors: s_last on first beat, then missing s_last on last beat
    send(11, 11, 11, 1'b1);
    chk("ferr1_err", 256'(err), 256'(1));
    chk("ferr1_ready", 256'(sif.s_ready), 256'(1));
    repeat (3) step();
    send(12, 12, 12, 1'b0);
    send(13, 13, 13, 1'b0);
    repeat (3) step();
    chk("ferr_no_start", 256'(n_start), 256'(2));
    chk("ferr_busy", 256'(busy), 256'(0));
    send(5, 5, 3, 1'b0);
    send(7, 8, 9, 1'b1);
    wait_start("ferr_recover_start");
    chk("ferr_recover_g0x", G_out[0].x, 256'(5));
    chk("ferr_recover_g0y", G_out[0].y, 256'(5));
    chk("ferr_recover_x1", x_out[1], 256'(9));
    chk("ferr_err_sticky", 256'(err), 256'(1));

    // Stale Done held across START and GUARD
    msm_done = 1'b1;
    step();
    step();
    msm_done = 1'b0;
    chk("stale_busy", 256'(busy), 256'(1));
    chk("stale_cnt", 256'(batches_issued), 256'(2));
    repeat (10) step();
    chk("stale_still_busy", 256'(busy), 256'(1));
    chk("stale_still_cnt", 256'(batches_issued), 256'(2));
    msm_done = 1'b1;
    step();
    msm_done = 1'b0;
    chk("stale_done_cnt", 256'(batches_issued), 256'(3));
    chk("stale_done_busy", 256'(busy), 256'(0));

    // Mid-run reset during WAIT with a partial batch pending
    send(2, 3, 4, 1'b0);
    send(5, 6, 7, 1'b1);
    wait_start("midrst_start");
    step(); step();
    send(9, 9, 9, 1'b0);
    chk("midrst_wait_busy", 256'(busy), 256'(1));
    chk("midrst_wait_g0x", G_out[0].x, 256'(2));
    msm_done = 1'b1;
    Reset_n = 1'b0;
    #1;
    chk("midrst_start_low", 256'(msm_start), 256'(0));
    step();
    Reset_n = 1'b1;
    chk_reset_state("midrst");
    repeat (3) step();
    chk("midrst_done_ignored_busy", 256'(busy), 256'(0));
    chk("midrst_done_ignored_cnt", 256'(batches_issued), 256'(0));
    msm_done = 1'b0;
    send(1, 2, 3, 1'b0);
    send(4, 5, 6, 1'b1);
    wait_start("midrst_fresh_start");
    chk("midrst_fresh_g0x", G_out[0].x, 256'(1));
    chk("midrst_fresh_x1", x_out[1], 256'(6));
    chk("midrst_fresh_err", 256'(err), 256'(0));
    msm_done = 1'b1;
    step(); step(); step();
    msm_done = 1'b0;
    chk("midrst_fresh_cnt", 256'(batches_issued), 256'(1));
    chk("midrst_fresh_busy", 256'(busy), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/msm_input_loader.md
# msm_input_loader

Upstream feeder for `msm_naive`. It accepts a stream of (point, scalar) pairs over a valid/ready handshake and collects them into two ping-pong banks of `LENGTH` entries each. When a bank is full, it presents that bank on the `G`/`x` array inputs of `msm_naive` and pulses `msm_start`, which drives the msm's active-high `Reset`. The other bank fills while the msm computes.

## Interface

**Parameters**
- `LENGTH`, default 2: pairs per batch. Must equal `msm_naive` `length`.

**Ports**
- `clk` in 1: clock.
- `Reset_n` in 1: reset. One clock; reset is synchronous and active-low.
- `s_valid` in 1: input pair valid.
- `s_ready` out 1: loader can accept a pair.
- `s_point` in `curve_point_t` (512): affine point {x, y}.
- `s_scalar` in 256: scalar.
- `s_last` in 1: marks the final pair of a batch.
- `G_out` out `curve_point_t [LENGTH-1:0]`: points of the read bank, connected to msm `G`.
- `x_out` out `[255:0] [LENGTH-1:0]`: scalars of the read bank, connected to msm `x`.
- `msm_start` out 1: one-cycle pulse, connected to msm `Reset`.
- `msm_done` in 1: msm `Done` (level).
- `busy` out 1: high while an msm batch is in flight.
- `err` out 1: sticky framing error.
- `batches_issued` out 16: count of completed batches; wraps modulo 2^16.

## Operation

**Banks**
- Two banks: `bank[0..1]`, each holding `LENGTH` points and `LENGTH` scalars.
- Registers `wr_sel`, `rd_sel`, `wr_idx` (`$clog2(LENGTH)` bits) and `bank_full[1:0]`.

**Input side**
- `s_ready = !bank_full[wr_sel]`. This is registered-state only; it has no combinational path from `s_valid`.
- A transfer occurs on `s_valid && s_ready`. The pair is written to `bank[wr_sel][wr_idx]`.
- If `wr_idx < LENGTH-1` and `!s_last`: `wr_idx++`.
- If `wr_idx == LENGTH-1` and `s_last`: set `bank_full[wr_sel]`, toggle `wr_sel`, clear `wr_idx`.
- Framing error (`s_last` with `wr_idx < LENGTH-1`, or `!s_last` with `wr_idx == LENGTH-1`):
  - set `err`;
  - clear `wr_idx`;
  - discard the partial batch (bank not marked full, `wr_sel` unchanged).
- `err` clears only on reset.

**Launch FSM** (states IDLE, START, GUARD, WAIT)
- IDLE: if `bank_full[rd_sel]`, go to START.
- START: `msm_start = 1` for exactly this cycle; go to GUARD.
- GUARD: ignore `msm_done` for one cycle, so a stale Done from the previous run is not taken; go to WAIT.
- WAIT: on `msm_done`, clear `bank_full[rd_sel]`, toggle `rd_sel`, increment `batches_issued`, go to IDLE.
- `busy = (state != IDLE)`.

**Outputs**
- `G_out`/`x_out` always reflect `bank[rd_sel]` and are held stable from START through WAIT.
- The read bank is never written while it is full.

## Timing

**Reset** (`Reset_n` low at an edge):
- all bank contents 0 (so `G_out`, `x_out` = 0);
- `wr_sel = rd_sel = wr_idx = 0`; `bank_full = 0`;
- state IDLE; `msm_start = 0`; `busy = 0`; `err = 0`; `batches_issued = 0`;
- consequently `s_ready = 1` from the first cycle after reset.

**Reset mid-operation**
- An in-flight batch and any partial batch are dropped.
- `msm_start` is not asserted during reset.
- Any `msm_done` seen later is ignored until a new START.

**Latency**
- Final beat accepted at edge k: `bank_full` is set after edge k.
- If the FSM is IDLE, START occupies cycle k+1 to k+2, so `msm_start` is high in the cycle after edge k+1.
- Done sampled at edge j in WAIT: the next START is at the earliest two cycles later (IDLE, then START).

**Simultaneous events**
- A bank commit and a `msm_done` in the same cycle both take effect; the counters are independent.
- A commit to bank b and a launch check of bank b in the same cycle: the launch waits one cycle, because it sees the registered `bank_full`.

**Full condition**
- With both banks full, `s_ready = 0` until the next Done.

## Structure

- `curve_point_t` is taken from the existing `elliptic_curve_structs` package.
- Add `MSM_SCALAR_W = 256` to that package.
- The FSM state enum stays local to this module.
- Sub-module `msm_batch_bank`: one bank of `LENGTH` point/scalar registers with a synchronous write port (`we`, `idx`, `point`, `scalar`) and full-array read outputs. Instantiate it twice; `G_out`/`x_out` are muxed by `rd_sel`.

## Test plan

1. **Single batch, integration with `msm_naive`, `LENGTH=2`.**
   - Stimulus: send (6,1)/18, then (17,6)/80 with `s_last`.
   - Required: exactly one `msm_start` pulse; `G_out[0]=(6,1)`, `x_out[1]=80` held; on Done, R = (16,25), `batches_issued = 1`, `busy = 0`.
2. **Ping-pong.**
   - Stimulus: send batch B (same values, order swapped) while batch A runs.
   - Required: `s_ready` stays 1 during B; B's `msm_start` occurs ≥2 cycles after A's Done; `batches_issued = 2`.
3. **Back-pressure.**
   - Stimulus: fill both banks while `msm_done` is held low.
   - Required: `s_ready = 0`; a further `s_valid` is not consumed. After Done, `s_ready = 1` in the next cycle.
4. **Framing error.**
   - Stimulus: `s_last` on the first beat.
   - Required: `err = 1`, no `msm_start`, `wr_idx = 0`. A following valid batch is still launched normally; `err` stays 1.
5. **Stale Done.**
   - Stimulus: model msm holds `msm_done = 1` for the START and GUARD cycles, drops it, then raises it 10 cycles later.
   - Required: completion is registered only at the later rise.
6. **Mid-run reset.**
   - Stimulus: `Reset_n` low for 1 cycle during WAIT.
   - Required: all outputs return to their reset values; the next full batch produces a fresh START.
